// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// State encoding for the frame FSM plus frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i/rdata_o,
//        full_o, empty_o, count_o (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en, rd_en;

    assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];

    // A push into a full FIFO still lands when a pop frees the slot
    // in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (wr_en) begin
            wr_d = wr_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rd_d = rd_q + ADDR_W'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers bytes from the core's 9-bit UART port and sends them as 8N1.
// Ports: clock, reset_n, uart_in[8]=strobe/[7:0]=byte, txd, busy,
//        fifo_full, fifo_count, overflow (sticky drop flag).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [8:0]        uart_in,
    output logic              txd,
    output logic              busy,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ovf_q, ovf_d;

    logic        push;
    logic        pop;
    logic        bit_end;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;

    assign push    = uart_in[8];
    assign bit_end = (baud_q == '0);

    sync_fifo #(
        .WIDTH  (8),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i (uart_in[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pops are decided from the registered FIFO state, so a byte pushed
    // this cycle is never popped in the same cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame, no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        baud_d  = BAUD_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the registered state, one clock behind it.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign ovf_d = ovf_q | (push & fifo_full & ~pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign txd      = txd_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a line-side UART receiver.
// Ports: none.
module tb_uart_tx_serializer;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [8:0]    uart_in = '0;
    logic          txd;
    logic          busy;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] rxq[$];
    int         rxs[$];
    int         frame_err = 0;

    uart_tx_serializer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .uart_in    (uart_in),
        .txd        (txd),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Receiver: samples mid-bit on falling edges, 16 clocks per bit.
    initial begin : rx_model
        bit         act;
        int         cnt;
        int         st;
        logic [7:0] sh;
        act = 1'b0;
        cnt = 0;
        st  = 0;
        sh  = '0;
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (txd === 1'b0) begin
                    act = 1'b1;
                    cnt = 1;
                    st  = cyc;
                end
            end else begin
                if (cnt >= 24 && cnt <= 136 && ((cnt - 24) % 16) == 0)
                    sh[(cnt - 24) / 16] = txd;
                if (cnt == 152) begin
                    if (txd !== 1'b1) frame_err = frame_err + 1;
                    rxq.push_back(sh);
                    rxs.push_back(st);
                end
                cnt = cnt + 1;
                if (cnt == 10 * CLK_DIV) act = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        uart_in = '0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        uart_in = '0;
        reset_n = 1'b0;
        tick(3);
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL reset_txd: got %b want 1", txd);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_vec++;
        if (fifo_full !== 1'b0) begin
            n_err++; $display("FAIL reset_full: got %b want 0", fifo_full);
        end
        n_vec++;
        if (fifo_count !== 5'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_frame();
        logic [7:0] exp;
        exp = 8'h41;
        rxq.delete();
        uart_in = 9'h141;
        tick();
        uart_in = '0;
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL lat_e0: got %b want 1", txd);
        end
        tick();
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL lat_e1: got %b want 1", txd);
        end
        tick();
        n_vec++;
        if (txd !== 1'b0) begin
            n_err++; $display("FAIL lat_e2: got %b want 0", txd);
        end
        tick(8);
        n_vec++;
        if (txd !== 1'b0) begin
            n_err++; $display("FAIL start_mid: got %b want 0", txd);
        end
        for (int k = 0; k < 8; k++) begin
            tick(16);
            n_vec++;
            if (txd !== exp[k]) begin
                n_err++;
                $display("FAIL data_bit%0d: got %b want %b", k, txd, exp[k]);
            end
        end
        tick(16);
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL stop_bit: got %b want 1", txd);
        end
        tick(6);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL busy_e160: got %b want 1", busy);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL busy_e161: got %b want 0", busy);
        end
        tick(5);
        n_vec++;
        if (rxq.size() != 1 || rxq[0] !== 8'h41) begin
            n_err++; $display("FAIL rx_single: got %0d bytes want 1 x 41", rxq.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int n;
        exp[0] = 8'h48;
        exp[1] = 8'h69;
        exp[2] = 8'h0A;
        rxq.delete();
        rxs.delete();
        for (int i = 0; i < 3; i++) begin
            uart_in = {1'b1, exp[i]};
            tick();
        end
        uart_in = '0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        n_vec++;
        if (n != 479) begin
            n_err++; $display("FAIL b2b_duration: got %0d want 479", n);
        end
        tick(5);
        n_vec++;
        if (rxq.size() != 3) begin
            n_err++; $display("FAIL b2b_count: got %0d want 3", rxq.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                n_err++; $display("FAIL b2b_byte%0d: want %h", i, exp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (i >= rxs.size() || rxs[i] - rxs[i-1] != 160) begin
                n_err++; $display("FAIL b2b_gap%0d: want 160 clocks", i);
            end
        end
    endtask

    task automatic test_overflow();
        int maxc;
        bit saw_full;
        int n;
        do_reset();
        rxq.delete();
        maxc = 0;
        saw_full = 1'b0;
        uart_in = 9'h1A0;
        tick();
        uart_in = '0;
        tick(20);
        for (int i = 0; i < 20; i++) begin
            uart_in = {1'b1, 8'(i)};
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            if (fifo_full === 1'b1) saw_full = 1'b1;
        end
        uart_in = '0;
        n_vec++;
        if (saw_full !== 1'b1) begin
            n_err++; $display("FAIL ovf_full: got %b want 1", saw_full);
        end
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            tick();
            n++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL ovf_drain: busy still %b want 0", busy);
        end
        n_vec++;
        if (maxc > 16) begin
            n_err++; $display("FAIL ovf_maxcount: got %0d want <=16", maxc);
        end
        tick(5);
        n_vec++;
        if (rxq.size() != 17) begin
            n_err++; $display("FAIL ovf_frames: got %0d want 17", rxq.size());
        end
        n_vec++;
        if (rxq.size() < 1 || rxq[0] !== 8'hA0) begin
            n_err++; $display("FAIL ovf_first: want a0");
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (i + 1 >= rxq.size() || rxq[i+1] !== 8'(i)) begin
                n_err++; $display("FAIL ovf_byte%0d: want %h", i, 8'(i));
            end
        end
    endtask

    task automatic test_full_at_stop();
        do_reset();
        rxq.delete();
        uart_in = 9'h155;
        tick();
        for (int i = 0; i < 16; i++) begin
            uart_in = {1'b1, 8'(8'h80 + i)};
            tick();
        end
        uart_in = '0;
        tick(144);
        n_vec++;
        if (fifo_count !== 5'd16 || fifo_full !== 1'b1) begin
            n_err++; $display("FAIL stop_prefull: got %0d want 16", fifo_count);
        end
        uart_in = 9'h1EE;
        tick();
        uart_in = '0;
        n_vec++;
        if (fifo_count !== 5'd16) begin
            n_err++; $display("FAIL stop_count: got %0d want 16", fifo_count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL stop_ovf: got %b want 0", overflow);
        end
        uart_in = 9'h1EF;
        tick();
        uart_in = '0;
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL full_drop_ovf: got %b want 1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        int bad;
        tick(40);
        n0 = rxq.size();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL mid_txd: got %b want 1", txd);
        end
        n_vec++;
        if (fifo_count !== 5'd0) begin
            n_err++; $display("FAIL mid_count: got %0d want 0", fifo_count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL mid_ovf: got %b want 0", overflow);
        end
        n_vec++;
        if (busy !== 1'b0 || fifo_full !== 1'b0) begin
            n_err++; $display("FAIL mid_busy: got %b/%b want 0/0", busy, fifo_full);
        end
        tick(2);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad);
        end
        n_vec++;
        if (rxq.size() != n0) begin
            n_err++; $display("FAIL mid_frames: got %0d want %0d", rxq.size(), n0);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [7:0] e;
        do_reset();
        rxq.delete();
        frame_err = 0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                uart_in = {1'b1, 8'((b * 10 + i) * 37 + 5)};
                tick();
            end
            uart_in = '0;
            tick(1700);
        end
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        tick(5);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL wrap_ovf: got %b want 0", overflow);
        end
        n_vec++;
        if (rxq.size() != 40) begin
            n_err++; $display("FAIL wrap_count: got %0d want 40", rxq.size());
        end
        n_vec++;
        if (frame_err != 0) begin
            n_err++; $display("FAIL wrap_stop: got %0d bad stops want 0", frame_err);
        end
        for (int i = 0; i < 40; i++) begin
            e = 8'(i * 37 + 5);
            n_vec++;
            if (i >= rxq.size() || rxq[i] !== e) begin
                n_err++; $display("FAIL wrap_byte%0d: want %h", i, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_at_stop();
        test_reset_mid_frame();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
